peri_timer_gpio: RTL



---
 rtl/peri_timer_gpio_pkg.sv | 41 ++++
 rtl/peri_timer_core.sv | 54 +++++
 rtl/peri_timer_gpio.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/peri_timer_gpio_pkg.sv
// Shared definitions for the peripheral timer/GPIO responder: register
// offsets (word index inside the window), CTRL layout, reset values and a
// byte-enable merge helper.
package peri_timer_gpio_pkg;

  localparam logic [2:0] REG_LED      = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_COMPARE  = 3'd4;
  localparam logic [2:0] REG_STATUS   = 3'd5;
  localparam logic [2:0] REG_RSV0     = 3'd6;
  localparam logic [2:0] REG_RSV1     = 3'd7;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_IRQ_EN     = 2;

  typedef struct packed {
    logic irq_en;
    logic autoreload;
    logic en;
  } ctrl_t;

  localparam ctrl_t       RST_CTRL     = '0;
  localparam logic [15:0] RST_PRESCALE = 16'h0000;
  localparam logic [31:0] RST_COUNT    = 32'h0000_0000;
  localparam logic [31:0] RST_COMPARE  = 32'hFFFF_FFFF;

  // Replace the bytes of old selected by be with the matching bytes of wd.
  function automatic logic [31:0] be_merge(input logic [31:0] old,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/peri_timer_core.sv
// Prescaled 32-bit timer: 16-bit divider, counter, compare and sticky MATCH.
// Software writes arrive as strobes; a COUNT write beats a same-cycle tick.
module peri_timer_core
  import peri_timer_gpio_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        autoreload_i,
  input  logic [15:0] prescale_i,
  input  logic [31:0] compare_i,
  input  logic        div_clr_i,
  input  logic        count_we_i,
  input  logic [31:0] count_wdata_i,
  input  logic        match_clr_i,
  output logic [31:0] count_o,
  output logic        match_o
);

  logic [15:0] div_q, div_d;
  logic [31:0] count_q, count_d;
  logic        match_q, match_d;
  logic        tick, hit;

  assign tick = en_i & (div_q == prescale_i);

  // Divider, counter and MATCH next state; set of MATCH beats W1C.
  always_comb begin
    div_d = div_q + 16'd1;
    if (div_clr_i | ~en_i | tick) div_d = '0;
    hit     = tick & ~count_we_i & (count_q == compare_i);
    count_d = count_q;
    if (count_we_i)  count_d = count_wdata_i;
    else if (tick)   count_d = (hit & autoreload_i) ? '0 : count_q + 32'd1;
    match_d = hit | (match_q & ~match_clr_i);
  end

  // Timer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      count_q <= RST_COUNT;
      match_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      match_q <= match_d;
    end
  end

  assign count_o = count_q;
  assign match_o = match_q;

endmodule

// File: rtl/peri_timer_gpio.sv
// Peripheral-bus responder: LED register plus prescaled timer with
// compare-match interrupt. Zero-wait grant, one-cycle registered response.
// Optional macro PERI_TIMER_GPIO_ERR_EN adds peri_err for reserved offsets
// and partial stores to COUNT/COMPARE (those stores are then dropped).
module peri_timer_gpio
  import peri_timer_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
  parameter logic [31:0] WIN_MASK  = 32'h0000_001F,
  parameter int          LED_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      peri_addr,
  input  logic             peri_req,
  input  logic             peri_write,
  input  logic [3:0]       peri_be,
  input  logic [31:0]      peri_wdata,
  output logic             peri_gnt,
  output logic             peri_rvalid,
  output logic [31:0]      peri_rdata,
`ifdef PERI_TIMER_GPIO_ERR_EN
  output logic             peri_err,
`endif
  output logic [LED_W-1:0] led_o,
  output logic             timer_irq_o
);

  logic             sel, wr, bad, wr_ok;
  logic [2:0]       off;
  logic [31:0]      rd_val, wmerge, count;
  logic             match;
  logic [LED_W-1:0] led_q, led_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [15:0]      pre_q, pre_d;
  logic [31:0]      cmp_q, cmp_d;
  logic             irq_q, rvalid_q;
  logic [31:0]      rdata_q;

  assign sel   = peri_req & ((peri_addr & ~WIN_MASK) == BASE_ADDR);
  assign off   = peri_addr[4:2];
  assign wr    = sel & peri_write;
`ifdef PERI_TIMER_GPIO_ERR_EN
  assign bad   = sel & ((off == REG_RSV0) | (off == REG_RSV1) |
                 (peri_write & (peri_be != 4'hF) &
                  ((off == REG_COUNT) | (off == REG_COMPARE))));
`else
  assign bad   = 1'b0;
`endif
  assign wr_ok = wr & ~bad;

  // Read mux over the current register contents.
  always_comb begin
    rd_val = '0;
    case (off)
      REG_LED:      rd_val[LED_W-1:0] = led_q;
      REG_CTRL:     rd_val[2:0]       = ctrl_q;
      REG_PRESCALE: rd_val[15:0]      = pre_q;
      REG_COUNT:    rd_val            = count;
      REG_COMPARE:  rd_val            = cmp_q;
      REG_STATUS:   rd_val[0]         = match;
      REG_RSV0,
      REG_RSV1:     rd_val            = '0;
    endcase
  end

  // Stores merge into the addressed register's current value bytewise.
  assign wmerge = be_merge(rd_val, peri_wdata, peri_be);

  // Register-file next state.
  always_comb begin
    led_d  = led_q;
    ctrl_d = ctrl_q;
    pre_d  = pre_q;
    cmp_d  = cmp_q;
    if (wr_ok) begin
      case (off)
        REG_LED:      led_d = wmerge[LED_W-1:0];
        REG_CTRL: begin
          ctrl_d.en         = wmerge[CTRL_EN];
          ctrl_d.autoreload = wmerge[CTRL_AUTORELOAD];
          ctrl_d.irq_en     = wmerge[CTRL_IRQ_EN];
        end
        REG_PRESCALE: pre_d = wmerge[15:0];
        REG_COMPARE:  cmp_d = wmerge;
        default: ;
      endcase
    end
  end

  // Register file, interrupt and bus response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q    <= '0;
      ctrl_q   <= RST_CTRL;
      pre_q    <= RST_PRESCALE;
      cmp_q    <= RST_COMPARE;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      led_q    <= led_d;
      ctrl_q   <= ctrl_d;
      pre_q    <= pre_d;
      cmp_q    <= cmp_d;
      irq_q    <= match & ctrl_q.irq_en;
      rvalid_q <= sel;
      rdata_q  <= (sel & ~peri_write) ? rd_val : '0;
    end
  end

`ifdef PERI_TIMER_GPIO_ERR_EN
  logic err_q;
  // Error flag travels with the response.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= bad;
  end
  assign peri_err = err_q;
`endif

  peri_timer_core u_core (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (ctrl_q.en),
    .autoreload_i  (ctrl_q.autoreload),
    .prescale_i    (pre_q),
    .compare_i     (cmp_q),
    .div_clr_i     (wr_ok & ((off == REG_PRESCALE) | (off == REG_CTRL))),
    .count_we_i    (wr_ok & (off == REG_COUNT)),
    .count_wdata_i (wmerge),
    .match_clr_i   (wr_ok & (off == REG_STATUS) & peri_be[0] & peri_wdata[0]),
    .count_o       (count),
    .match_o       (match)
  );

  assign peri_gnt    = sel;
  assign peri_rvalid = rvalid_q;
  assign peri_rdata  = rdata_q;
  assign led_o       = led_q;
  assign timer_irq_o = irq_q;

endmodule
